// File: rtl/sa_autosa_pdp_pkg.sv
// Shared constants and types for the AUTOSA PDP pooling datapath.
package sa_autosa_pdp_pkg;

    localparam int PDP_LANES = 8;
    localparam int PDP_IW    = 8;
    localparam int PDP_OW    = 11;

    localparam logic [1:0] POOL_MAX = 2'd0;
    localparam logic [1:0] POOL_MIN = 2'd1;
    localparam logic [1:0] POOL_SUM = 2'd2;

    localparam int INFO_LINE_END = 73;
    localparam int INFO_CUBE_END = 77;

    typedef struct packed {
        logic [1:0] method;
        logic [2:0] km1;
    } cal1d_cfg_t;

endpackage

// File: rtl/sa_autosa_pdp_cal1d_lane.sv
// One pooling lane: sign-extends its input and folds it into a running
// max/min/sum accumulator for the current window.
module sa_autosa_pdp_cal1d_lane
    import sa_autosa_pdp_pkg::*;
#(
    parameter int IW = PDP_IW,
    parameter int OW = PDP_OW
) (
    input  logic          autosa_core_clk,
    input  logic          autosa_core_rstn,
    input  logic          clr,
    input  logic          en,
    input  logic          first,
    input  logic [1:0]    method,
    input  logic [IW-1:0] din,
    output logic [OW-1:0] res
);

    logic signed [OW-1:0] acc;
    logic signed [OW-1:0] ext;
    logic signed [OW-1:0] red;

    assign ext = {{(OW-IW){din[IW-1]}}, din};

    // Reserved method encoding falls through to max.
    always_comb begin
        red = ext;
        if (!first) begin
            case (method)
                POOL_MIN: red = (ext < acc) ? ext : acc;
                POOL_SUM: red = acc + ext;
                default:  red = (ext > acc) ? ext : acc;
            endcase
        end
    end

    assign res = red;

    always_ff @(posedge autosa_core_clk) begin
        if (!autosa_core_rstn)
            acc <= '0;
        else if (en)
            acc <= red;
        else if (clr)
            acc <= '0;
    end

endmodule

// File: rtl/sa_autosa_pdp_cal1d.sv
// Horizontal pooling: reduces non-overlapping windows of K input words
// (cut early at line/cube end) into one widened output word.
module sa_autosa_pdp_cal1d
    import sa_autosa_pdp_pkg::*;
#(
    parameter int LANES = PDP_LANES,
    parameter int IW    = PDP_IW,
    parameter int OW    = PDP_OW
) (
    input  logic                  autosa_core_clk,
    input  logic                  autosa_core_rstn,
    input  logic                  reg2dp_op_en,
    input  logic [1:0]            reg2dp_pooling_method,
    input  logic [2:0]            reg2dp_kernel_width,
    input  logic [LANES*IW+13:0]  nan_preproc_pd,
    input  logic                  nan_preproc_pvld,
    output logic                  nan_preproc_prdy,
    output logic [LANES*OW+1:0]   pooling1d_pd,
    output logic                  pooling1d_pvld,
    input  logic                  pooling1d_prdy,
    output logic                  cal1d_layer_done
);

    logic       op_en_d1;
    logic       op_en_load;
    logic       load_in;
    logic       close;
    logic       first;
    logic       line_end;
    logic       cube_end;
    cal1d_cfg_t cfg;
    cal1d_cfg_t cfg_eff;
    logic [2:0] win_cnt;
    logic [2:0] cnt_eff;
    logic [LANES-1:0][OW-1:0] lane_res;
    logic       unused_info;

    assign unused_info = ^{nan_preproc_pd[INFO_CUBE_END-1:INFO_LINE_END+1],
                           nan_preproc_pd[INFO_LINE_END-1:LANES*IW]};

    assign op_en_load       = reg2dp_op_en & ~op_en_d1;
    assign nan_preproc_prdy = ~autosa_core_rstn | ~pooling1d_pvld | pooling1d_prdy;
    assign load_in          = autosa_core_rstn & nan_preproc_pvld & nan_preproc_prdy;
    assign line_end         = nan_preproc_pd[INFO_LINE_END];
    assign cube_end         = nan_preproc_pd[INFO_CUBE_END];

    // A word arriving with the enable edge already belongs to the new layer.
    assign cfg_eff = op_en_load ? cal1d_cfg_t'{reg2dp_pooling_method, reg2dp_kernel_width} : cfg;
    assign cnt_eff = op_en_load ? 3'd0 : win_cnt;
    assign first   = (cnt_eff == 3'd0);
    assign close   = load_in & ((cnt_eff == cfg_eff.km1) | line_end | cube_end);

    assign cal1d_layer_done = pooling1d_pvld & pooling1d_prdy & pooling1d_pd[LANES*OW+1];

    always_ff @(posedge autosa_core_clk) begin
        if (!autosa_core_rstn) begin
            op_en_d1 <= 1'b0;
            cfg      <= '0;
        end else begin
            op_en_d1 <= reg2dp_op_en;
            if (op_en_load)
                cfg <= cfg_eff;
        end
    end

    always_ff @(posedge autosa_core_clk) begin
        if (!autosa_core_rstn)
            win_cnt <= 3'd0;
        else if (load_in)
            win_cnt <= close ? 3'd0 : cnt_eff + 3'd1;
        else if (op_en_load)
            win_cnt <= 3'd0;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sa_autosa_pdp_cal1d_lane #(.IW(IW), .OW(OW)) u_lane (
            .autosa_core_clk  (autosa_core_clk),
            .autosa_core_rstn (autosa_core_rstn),
            .clr              (op_en_load),
            .en               (load_in),
            .first            (first),
            .method           (cfg_eff.method),
            .din              (nan_preproc_pd[i*IW +: IW]),
            .res              (lane_res[i])
        );
    end

    // A closing window overrides a same-cycle drain, so pvld stays up.
    always_ff @(posedge autosa_core_clk) begin
        if (!autosa_core_rstn) begin
            pooling1d_pvld <= 1'b0;
            pooling1d_pd   <= '0;
        end else if (close) begin
            pooling1d_pvld <= 1'b1;
            pooling1d_pd   <= {cube_end, line_end, lane_res};
        end else if (pooling1d_prdy) begin
            pooling1d_pvld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sa_autosa_pdp_cal1d.sv
// Directed bench for the horizontal pooling stage: sum/max/min windows,
// early cuts, backpressure, mid-window re-enable and reset.
module tb_sa_autosa_pdp_cal1d;

    logic        clk = 1'b0;
    logic        rstn;
    logic        op_en;
    logic [1:0]  method;
    logic [2:0]  kw;
    logic [77:0] in_pd;
    logic        in_vld;
    logic        in_rdy;
    logic [89:0] out_pd;
    logic        out_vld;
    logic        out_rdy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic [89:0] stall_pd;

    always #5 clk = ~clk;

    sa_autosa_pdp_cal1d dut (
        .autosa_core_clk       (clk),
        .autosa_core_rstn      (rstn),
        .reg2dp_op_en          (op_en),
        .reg2dp_pooling_method (method),
        .reg2dp_kernel_width   (kw),
        .nan_preproc_pd        (in_pd),
        .nan_preproc_pvld      (in_vld),
        .nan_preproc_prdy      (in_rdy),
        .pooling1d_pd          (out_pd),
        .pooling1d_pvld        (out_vld),
        .pooling1d_prdy        (out_rdy),
        .cal1d_layer_done      (done)
    );

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [89:0] got, input logic [89:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    // lane0 carries v0, lanes 1..7 carry vr
    function automatic logic [77:0] mk(input int v0, input int vr, input bit le, input bit ce);
        logic [77:0] p = '0;
        p[7:0] = v0[7:0];
        for (int i = 1; i < 8; i++) p[8*i +: 8] = vr[7:0];
        p[73] = le;
        p[77] = ce;
        return p;
    endfunction

    function automatic logic [89:0] ex(input int v0, input int vr, input bit le, input bit ce);
        logic [89:0] e = '0;
        e[10:0] = v0[10:0];
        for (int i = 1; i < 8; i++) e[11*i +: 11] = vr[10:0];
        e[88] = le;
        e[89] = ce;
        return e;
    endfunction

    task automatic send(input logic [77:0] pd);
        bit ok = 1'b0;
        in_pd  = pd;
        in_vld = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_rdy;
            @(posedge clk); #1;
        end
        in_vld = 1'b0;
        if (!ok) chk("send_timeout", 90'd0, 90'd1);
    endtask

    task automatic start_layer(input logic [1:0] m, input logic [2:0] k);
        op_en = 1'b0;
        @(posedge clk); #1;
        method = m;
        kw     = k;
        op_en  = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; op_en = 1'b0; method = 2'd0; kw = 3'd0;
        in_pd = '0; in_vld = 1'b0; out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pvld", 90'(out_vld), 90'd0);
        chk("rst_pd",   out_pd,       90'd0);
        chk("rst_prdy", 90'(in_rdy),  90'd1);
        chk("rst_done", 90'(done),    90'd0);
        rstn = 1'b1;

        // K=4 sum: 1..4 -> 10, 5..8 -> 26; output one cycle after 4th word
        start_layer(2'd2, 3'd3);
        send(mk(1, -1, 0, 0)); send(mk(2, -2, 0, 0)); send(mk(3, -3, 0, 0));
        chk("sum_early_vld", 90'(out_vld), 90'd0);
        send(mk(4, -4, 0, 0));
        chk("sum1_vld", 90'(out_vld), 90'd1);
        chk("sum1_pd",  out_pd, ex(10, -10, 0, 0));
        send(mk(5, -5, 0, 0));
        chk("sum_drain_vld", 90'(out_vld), 90'd0);
        send(mk(6, -6, 0, 0)); send(mk(7, -7, 0, 0)); send(mk(8, -8, 0, 0));
        chk("sum2_vld", 90'(out_vld), 90'd1);
        chk("sum2_pd",  out_pd, ex(26, -26, 0, 0));

        // K=3 max, then a 2-word window cut by line_end
        start_layer(2'd0, 3'd2);
        send(mk(-5, 10, 0, 0)); send(mk(7, -3, 0, 0)); send(mk(-128, 0, 0, 0));
        chk("max1_pd", out_pd, ex(7, 10, 0, 0));
        send(mk(3, 1, 0, 0)); send(mk(-1, 2, 1, 0));
        chk("max2_vld", 90'(out_vld), 90'd1);
        chk("max2_pd",  out_pd, ex(3, 2, 1, 0));

        // K=8 min, all -128, cube_end on last word
        start_layer(2'd1, 3'd7);
        done_cnt = 0;
        for (int i = 0; i < 7; i++) send(mk(-128, -128, 0, 0));
        chk("min_partial_vld", 90'(out_vld), 90'd0);
        send(mk(-128, -128, 0, 1));
        chk("min_pd",   out_pd, ex(-128, -128, 0, 1));
        chk("min_done", 90'(done), 90'd1);
        @(posedge clk); #1;
        chk("min_done_clr", 90'(done), 90'd0);
        chk("min_done_cnt", 90'(done_cnt), 90'd1);

        // K=2 sum with 5-cycle downstream stall
        start_layer(2'd2, 3'd1);
        send(mk(1, 3, 0, 0)); send(mk(2, 4, 0, 0));
        chk("bp_pd0", out_pd, ex(3, 7, 0, 0));
        out_rdy  = 1'b0;
        stall_pd = out_pd;
        in_pd    = mk(10, -10, 0, 0);
        in_vld   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_prdy",   90'(in_rdy),  90'd0);
        chk("bp_vld",    90'(out_vld), 90'd1);
        chk("bp_stable", out_pd, stall_pd);
        out_rdy = 1'b1;
        @(posedge clk); #1;
        chk("bp_drain_vld", 90'(out_vld), 90'd0);
        in_pd = mk(20, -5, 0, 0);
        @(posedge clk); #1;
        in_vld = 1'b0;
        chk("bp_sum_pd", out_pd, ex(30, -15, 0, 0));

        // Re-enable mid-window with K=1; partial window discarded
        start_layer(2'd2, 3'd3);
        send(mk(1, 1, 0, 0)); send(mk(2, 2, 0, 0));
        op_en = 1'b0;
        @(posedge clk); #1;
        op_en  = 1'b1;
        kw     = 3'd0;
        in_pd  = mk(9, -9, 0, 0);
        in_vld = 1'b1;
        @(posedge clk); #1;
        in_vld = 1'b0;
        chk("reen_vld", 90'(out_vld), 90'd1);
        chk("reen_pd",  out_pd, ex(9, -9, 0, 0));
        send(mk(-3, 4, 0, 0));
        chk("reen_pass_pd", out_pd, ex(-3, 4, 0, 0));

        // Reset with pending output, then reset mid-window
        start_layer(2'd2, 3'd1);
        send(mk(1, 1, 0, 0)); send(mk(2, 2, 0, 0));
        out_rdy = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst2_prdy", 90'(in_rdy), 90'd1);
        @(posedge clk); #1;
        rstn = 1'b1;
        chk("rst2_vld", 90'(out_vld), 90'd0);
        chk("rst2_pd",  out_pd, 90'd0);
        out_rdy = 1'b1;
        send(mk(5, 5, 0, 0));
        op_en = 1'b0;
        rstn  = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        send(mk(6, -6, 0, 0));
        chk("rst3_vld", 90'(out_vld), 90'd1);
        chk("rst3_pd",  out_pd, ex(6, -6, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
